fir_coef_loader: RTL and testbench
==================================

Name: fir_coef_loader

Overview:
Loads a new coefficient set into the FIR filter's shadow tap bank. Coefficients arrive over a valid/ready stream, and the block writes them sequentially through a tap write port. When a complete, well-formed set has been received, the block issues a one-cycle bank swap so the filter switches coefficient sets atomically. It replaces file-based tap initialisation with run-time reprogramming from the host/control path.

Parameters:
TAP_WIDTH, 32, coefficient width in bits (signed two's complement).
TAP_COUNT, 128, number of taps in one complete set.
ADDR_WIDTH, $clog2(TAP_COUNT), tap address width (localparam, derived; not overridable).

Ports:
clk  input  1  clock.
reset_n  input  1  reset, asynchronous, active-low.
start  input  1  one-cycle pulse; begins a load when the block is IDLE.
s_valid  input  1  coefficient stream valid.
s_ready  output  1  coefficient stream ready.
s_data  input  TAP_WIDTH  coefficient word; tap 0 arrives first.
s_last  input  1  marks the final word of the set (the checksum word when COEF_CHECKSUM_EN is defined).
tap_we  output  1  shadow-bank write enable.
tap_addr  output  ADDR_WIDTH  shadow-bank write address.
tap_wdata  output  TAP_WIDTH  shadow-bank write data.
bank_swap  output  1  one-cycle pulse; filter adopts the shadow bank.
busy  output  1  high in any state other than IDLE and ERROR.
done  output  1  one-cycle pulse, coincident with bank_swap.
err  output  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the beat counter is 0. Reset is asynchronous and takes effect mid-load. No bank_swap is issued after a reset. Shadow-bank contents are then undefined, but the active bank is unaffected.
- A handshake (beat) occurs when s_valid=1 and s_ready=1 on a rising clk edge.
- States:
  - IDLE: s_ready=0. start=1 → LOAD; counter←0; err←0.
  - LOAD: s_ready=1.
    - Each beat registers tap_we=1, tap_addr=counter, tap_wdata=s_data on the next cycle (latency 1), then counter increments.
    - tap_we is 0 on cycles without a beat.
    - Beat with counter=TAP_COUNT-1 and s_last=1 → COMMIT (or CSUM when checksum is enabled).
    - Beat with s_last=1 and counter<TAP_COUNT-1 → ERROR (early last). That word is still written.
    - Beat with counter=TAP_COUNT-1 and s_last=0 → ERROR (missing last).
  - CSUM (COEF_CHECKSUM_EN only): s_ready=1.
    - One beat carries the checksum word; s_last must be 1.
    - Match and s_last=1 → COMMIT. Any mismatch, or s_last=0 → ERROR.
    - No tap write occurs for this beat.
  - COMMIT: bank_swap=1 and done=1 for exactly one cycle, placed after the final tap_we cycle. Then → IDLE.
  - ERROR: err=1, s_ready=0, no swap. start=1 → LOAD (err cleared, counter←0).
- start is ignored in LOAD, CSUM and COMMIT.
- s_valid is ignored when s_ready=0. Backpressure from the source (s_valid gaps) is tolerated indefinitely; there is no timeout.
- Counter never wraps. Its maximum value is TAP_COUNT-1.
- Minimum load time is TAP_COUNT beats plus 2 cycles (plus 1 beat with checksum).

Optional Feature:
COEF_CHECKSUM_EN
- Defined: a running sum of all TAP_COUNT coefficients, modulo 2^TAP_WIDTH (unsigned wrap), is accumulated. It is compared against one extra trailing stream word in the CSUM state. The s_last rules apply to that checksum word; the last coefficient must then carry s_last=0, otherwise → ERROR.
- Not defined: the CSUM state and the accumulator are absent. The last coefficient carries s_last=1.

Decomposition:
- Shared package fir_pkg:
  - default TAP_WIDTH and TAP_COUNT constants;
  - loader state enum (IDLE, LOAD, CSUM, COMMIT, ERROR).
- The filter consumes the same constants from fir_pkg.
- No sub-module. The checksum accumulator is a few lines inside an `ifdef block.

Test Plan:
- start, then 128 beats of coefficient value k in slot k with s_last on beat 127 → 128 tap_we pulses, addresses 0..127, data=k; one bank_swap/done pulse one cycle after the last write; err=0.
- Same load with random s_valid gaps and start pulsed mid-load → identical write sequence; start ignored; exactly one bank_swap.
- s_last on beat 10 → address 10 written; err=1; s_ready=0; no bank_swap. A following start clears err and a full load succeeds.
- 128 beats, none with s_last → ERROR after beat 127; no bank_swap.
- COEF_CHECKSUM_EN: all coefficients 0xFFFFFFFF → checksum 0xFFFFFF80 accepted → bank_swap. Checksum 0xFFFFFF81 → err=1, no swap.
- reset_n asserted low after beat 50 → all outputs 0 immediately; no bank_swap ever; next start restarts at address 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR constants and the coefficient-loader state encoding; the filter
// datapath imports the same defaults so both sides agree on bank geometry.
package fir_pkg;

    localparam int FIR_TAP_WIDTH = 32;
    localparam int FIR_TAP_COUNT = 128;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CSUM,
        COMMIT,
        ERROR
    } loader_state_e;

endpackage

// File: rtl/fir_coef_loader.sv
// Streams a coefficient set into the FIR shadow tap bank, then pulses bank_swap.
// Define COEF_CHECKSUM_EN to require a trailing modulo-2^TAP_WIDTH checksum word.
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter  int TAP_WIDTH  = FIR_TAP_WIDTH,
    parameter  int TAP_COUNT  = FIR_TAP_COUNT,
    localparam int ADDR_WIDTH = $clog2(TAP_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [TAP_WIDTH-1:0]  s_data,
    input  logic                  s_last,
    output logic                  tap_we,
    output logic [ADDR_WIDTH-1:0] tap_addr,
    output logic [TAP_WIDTH-1:0]  tap_wdata,
    output logic                  bank_swap,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TAP_COUNT - 1);

    loader_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  tap_we_q, tap_we_d;
    logic [ADDR_WIDTH-1:0] tap_addr_q, tap_addr_d;
    logic [TAP_WIDTH-1:0]  tap_wdata_q, tap_wdata_d;
    logic                  swap_q, swap_d;
    logic                  beat;
`ifdef COEF_CHECKSUM_EN
    logic [TAP_WIDTH-1:0]  csum_q, csum_d;
`endif

    assign s_ready = (state_q == LOAD) || (state_q == CSUM);
    assign beat    = s_valid && s_ready;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        tap_we_d    = 1'b0;
        tap_addr_d  = tap_addr_q;
        tap_wdata_d = tap_wdata_q;
        swap_d      = 1'b0;
`ifdef COEF_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            IDLE, ERROR: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
`ifdef COEF_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            LOAD: begin
                if (beat) begin
                    // Every accepted coefficient is written, even one that ends the set in error.
                    tap_we_d    = 1'b1;
                    tap_addr_d  = cnt_q;
                    tap_wdata_d = s_data;
`ifdef COEF_CHECKSUM_EN
                    csum_d      = csum_q + s_data;
`endif
                    if (cnt_q == LAST_ADDR) begin
`ifdef COEF_CHECKSUM_EN
                        state_d = s_last ? ERROR : CSUM;
`else
                        state_d = s_last ? COMMIT : ERROR;
`endif
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                        if (s_last) state_d = ERROR;
                    end
                end
            end
`ifdef COEF_CHECKSUM_EN
            CSUM: begin
                if (beat) state_d = (s_last && (s_data == csum_q)) ? COMMIT : ERROR;
            end
`endif
            COMMIT: begin
                // Swap is registered so it lands the cycle after the final tap write.
                swap_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == ERROR) err_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            tap_we_q    <= 1'b0;
            tap_addr_q  <= '0;
            tap_wdata_q <= '0;
            swap_q      <= 1'b0;
`ifdef COEF_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            tap_we_q    <= tap_we_d;
            tap_addr_q  <= tap_addr_d;
            tap_wdata_q <= tap_wdata_d;
            swap_q      <= swap_d;
`ifdef COEF_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign tap_we    = tap_we_q;
    assign tap_addr  = tap_addr_q;
    assign tap_wdata = tap_wdata_q;
    assign bank_swap = swap_q;
    assign done      = swap_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE) && (state_q != ERROR);

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: full loads, source gaps, framing errors,
// mid-load reset, and the checksum path when COEF_CHECKSUM_EN is defined.
module tb_fir_coef_loader;
    import fir_pkg::*;

    localparam int TW = FIR_TAP_WIDTH;
    localparam int TC = FIR_TAP_COUNT;
    localparam int AW = $clog2(TC);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [TW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          tap_we;
    logic [AW-1:0] tap_addr;
    logic [TW-1:0] tap_wdata;
    logic          bank_swap;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_pass   = 0;

    fir_coef_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .tap_we    (tap_we),
        .tap_addr  (tap_addr),
        .tap_wdata (tap_wdata),
        .bank_swap (bank_swap),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Monitor samples on the falling edge, away from the active edge.
    logic [AW-1:0] wr_addr_q[$];
    logic [TW-1:0] wr_data_q[$];
    int cyc = 0, last_wr_cyc = 0, swap_cyc = 0, swap_cnt = 0, done_bad = 0;

    always @(negedge clk) begin
        cyc++;
        if (tap_we === 1'b1) begin
            wr_addr_q.push_back(tap_addr);
            wr_data_q.push_back(tap_wdata);
            last_wr_cyc = cyc;
        end
        if (bank_swap === 1'b1) begin
            swap_cnt++;
            swap_cyc = cyc;
        end
        if (done !== bank_swap) done_bad++;
    end

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        swap_cnt = 0;
        done_bad = 0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        idle_cycles(1);
        start = 1'b0;
    endtask

    // Presents one word and returns 1 ns after the edge that accepts it.
    task automatic send_beat(input logic [TW-1:0] data, input logic last, input logic st);
        int w = 0;
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        start   = st;
        @(negedge clk);
        while (s_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            n_checks++;
            $display("FAIL beat_timeout: s_ready=%b required 1", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
    endtask

    // Full well-formed load with coefficient k in slot k.
    task automatic full_load(input bit gaps, input bit start_mid);
        logic [TW-1:0] sum = '0;
        pulse_start();
        for (int k = 0; k < TC; k++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) idle_cycles($urandom_range(1, 3));
            sum = sum + TW'(k);
`ifdef COEF_CHECKSUM_EN
            send_beat(TW'(k), 1'b0, start_mid && (k == 60));
`else
            send_beat(TW'(k), k == TC - 1, start_mid && (k == 60));
`endif
        end
`ifdef COEF_CHECKSUM_EN
        send_beat(sum, 1'b1, 1'b0);
`endif
        idle_cycles(4);
    endtask

    task automatic check_writes(input string name, input int n);
        int bad = 0;
        n_checks++;
        if (wr_addr_q.size() != n) bad++;
        else
            for (int k = 0; k < n; k++)
                if (wr_addr_q[k] !== AW'(k) || wr_data_q[k] !== TW'(k)) bad++;
        if (bad != 0)
            $display("FAIL %s: %0d writes with %0d bad, required %0d writes addr=data=index",
                     name, wr_addr_q.size(), bad, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({s_ready, tap_we, bank_swap, busy, done, err} !== 6'b0)
            $display("FAIL reset_flags: %b required 000000", {s_ready, tap_we, bank_swap, busy, done, err});
        else n_pass++;
        n_checks++;
        if (tap_addr !== '0 || tap_wdata !== '0)
            $display("FAIL reset_bus: addr=%0d data=%h required 0/0", tap_addr, tap_wdata);
        else n_pass++;
    endtask

    task automatic test_full_load();
        clear_mon();
        pulse_start();
        n_checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1) $display("FAIL load_busy: busy=%b s_ready=%b required 1/1", busy, s_ready);
        else n_pass++;
        for (int k = 0; k < TC; k++)
`ifdef COEF_CHECKSUM_EN
            send_beat(TW'(k), 1'b0, 1'b0);
        send_beat(TW'(8128), 1'b1, 1'b0);
`else
            send_beat(TW'(k), k == TC - 1, 1'b0);
`endif
        idle_cycles(4);
        check_writes("full_writes", TC);
        n_checks++;
        if (swap_cnt !== 1) $display("FAIL full_swaps: %0d required 1", swap_cnt);
        else n_pass++;
`ifdef COEF_CHECKSUM_EN
        n_checks++;
        if (swap_cyc !== last_wr_cyc + 2) $display("FAIL swap_timing: swap-lastwr=%0d required 2", swap_cyc - last_wr_cyc);
        else n_pass++;
`else
        n_checks++;
        if (swap_cyc !== last_wr_cyc + 1) $display("FAIL swap_timing: swap-lastwr=%0d required 1", swap_cyc - last_wr_cyc);
        else n_pass++;
`endif
        n_checks++;
        if (done_bad !== 0 || err !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0)
            $display("FAIL full_end: done_bad=%0d err=%b busy=%b s_ready=%b required 0/0/0/0", done_bad, err, busy, s_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_mon();
        full_load(1'b1, 1'b1);
        check_writes("gap_writes", TC);
        n_checks++;
        if (swap_cnt !== 1 || err !== 1'b0 || done_bad !== 0)
            $display("FAIL gap_swap: swaps=%0d err=%b done_bad=%0d required 1/0/0", swap_cnt, err, done_bad);
        else n_pass++;
    endtask

    task automatic test_early_last();
        clear_mon();
        pulse_start();
        for (int k = 0; k <= 10; k++) send_beat(TW'(k), k == 10, 1'b0);
        idle_cycles(2);
        check_writes("early_writes", 11);
        n_checks++;
        if (err !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0 || swap_cnt !== 0)
            $display("FAIL early_err: err=%b s_ready=%b busy=%b swaps=%0d required 1/0/0/0", err, s_ready, busy, swap_cnt);
        else n_pass++;
        // Stream words are ignored while in ERROR.
        s_valid = 1'b1;
        idle_cycles(3);
        s_valid = 1'b0;
        n_checks++;
        if (wr_addr_q.size() !== 11 || err !== 1'b1) $display("FAIL err_ignore: writes=%0d err=%b required 11/1", wr_addr_q.size(), err);
        else n_pass++;
        clear_mon();
        pulse_start();
        n_checks++;
        if (err !== 1'b0) $display("FAIL err_clear: err=%b required 0", err);
        else n_pass++;
        for (int k = 0; k < TC; k++)
`ifdef COEF_CHECKSUM_EN
            send_beat(TW'(k), 1'b0, 1'b0);
        send_beat(TW'(8128), 1'b1, 1'b0);
`else
            send_beat(TW'(k), k == TC - 1, 1'b0);
`endif
        idle_cycles(4);
        check_writes("recover_writes", TC);
        n_checks++;
        if (swap_cnt !== 1 || err !== 1'b0) $display("FAIL recover_swap: swaps=%0d err=%b required 1/0", swap_cnt, err);
        else n_pass++;
    endtask

`ifndef COEF_CHECKSUM_EN
    task automatic test_missing_last();
        clear_mon();
        pulse_start();
        for (int k = 0; k < TC; k++) send_beat(TW'(k), 1'b0, 1'b0);
        idle_cycles(3);
        check_writes("nolast_writes", TC);
        n_checks++;
        if (err !== 1'b1 || swap_cnt !== 0 || s_ready !== 1'b0)
            $display("FAIL nolast_err: err=%b swaps=%0d s_ready=%b required 1/0/0", err, swap_cnt, s_ready);
        else n_pass++;
    endtask
`else
    task automatic test_checksum();
        logic [TW-1:0] csum_word;
        for (int pass = 0; pass < 2; pass++) begin
            csum_word = (pass == 0) ? 32'hFFFF_FF80 : 32'hFFFF_FF81;
            clear_mon();
            pulse_start();
            for (int k = 0; k < TC; k++) send_beat('1, 1'b0, 1'b0);
            send_beat(csum_word, 1'b1, 1'b0);
            idle_cycles(4);
            n_checks++;
            if (wr_addr_q.size() !== TC) $display("FAIL csum_writes: %0d required %0d", wr_addr_q.size(), TC);
            else n_pass++;
            n_checks++;
            if (swap_cnt !== (pass == 0 ? 1 : 0) || err !== (pass == 0 ? 1'b0 : 1'b1))
                $display("FAIL csum_result%0d: swaps=%0d err=%b required %0d/%0d", pass, swap_cnt, err, pass == 0 ? 1 : 0, pass);
            else n_pass++;
        end
        // s_last on the final coefficient is a framing error in checksum mode.
        clear_mon();
        pulse_start();
        for (int k = 0; k < TC; k++) send_beat(TW'(k), k == TC - 1, 1'b0);
        idle_cycles(3);
        n_checks++;
        if (err !== 1'b1 || swap_cnt !== 0) $display("FAIL csum_lastcoef: err=%b swaps=%0d required 1/0", err, swap_cnt);
        else n_pass++;
    endtask
`endif

    task automatic test_reset_mid_load();
        clear_mon();
        pulse_start();
        for (int k = 0; k <= 50; k++) send_beat(TW'(k), 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({s_ready, tap_we, bank_swap, busy, done, err} !== 6'b0 || tap_addr !== '0 || tap_wdata !== '0)
            $display("FAIL midreset_outputs: flags=%b addr=%0d data=%h required all 0",
                     {s_ready, tap_we, bank_swap, busy, done, err}, tap_addr, tap_wdata);
        else n_pass++;
        idle_cycles(2);
        reset_n = 1'b1;
        idle_cycles(4);
        n_checks++;
        if (swap_cnt !== 0 || busy !== 1'b0) $display("FAIL midreset_noswap: swaps=%0d busy=%b required 0/0", swap_cnt, busy);
        else n_pass++;
        clear_mon();
        full_load(1'b0, 1'b0);
        check_writes("restart_writes", TC);
        n_checks++;
        if (swap_cnt !== 1) $display("FAIL restart_swap: %0d required 1", swap_cnt);
        else n_pass++;
    endtask

    initial begin
        idle_cycles(2);
        test_reset();
        reset_n = 1'b1;
        idle_cycles(2);
        test_full_load();
        test_back_to_back();
        test_early_last();
`ifndef COEF_CHECKSUM_EN
        test_missing_last();
`else
        test_checksum();
`endif
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
